// File: rtl/pe2ddr_sched_if.sv
// rtl/pe2ddr_sched_if.sv - layer command, generator and DDR write-address bundle for pe2ddr_sched
interface pe2ddr_sched_if #(
  parameter int ADDR_W = 32,
  parameter int LEN_W  = 16,
  parameter int TILE_W = 8
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic [3:0]        cmd_layer_type;
  logic              cmd_pooling;
  logic              cmd_relu;
  logic [3:0]        cmd_ch_num;
  logic [3:0]        cmd_pix_num;
  logic [3:0]        cmd_row_num;
  logic [5:0]        cmd_shift;
  logic [3:0]        cmd_pe_mask;
  logic [TILE_W-1:0] cmd_tile_num;
  logic [ADDR_W-1:0] cmd_act_base;
  logic [ADDR_W-1:0] cmd_act_stride;
  logic [LEN_W-1:0]  cmd_act_len;
  logic [ADDR_W-1:0] cmd_mask_base;
  logic [ADDR_W-1:0] cmd_mask_stride;
  logic [LEN_W-1:0]  cmd_mask_len;

  logic              dg_start;
  logic              dg_done;
  logic [3:0]        dg_layer_type;
  logic              dg_pooling;
  logic              dg_relu;
  logic [3:0]        dg_ch_num;
  logic [3:0]        dg_pix_num;
  logic [3:0]        dg_row_num;
  logic [5:0]        dg_shift;
  logic [1:0]        dg_pe_sel;

  logic              wcmd1_valid;
  logic              wcmd1_ready;
  logic [ADDR_W-1:0] wcmd1_addr;
  logic [LEN_W-1:0]  wcmd1_len;
  logic              wcmd2_valid;
  logic              wcmd2_ready;
  logic [ADDR_W-1:0] wcmd2_addr;
  logic [LEN_W-1:0]  wcmd2_len;

  logic              layer_done;
  logic              busy;
  logic [31:0]       perf_busy_cycles;
  logic [31:0]       perf_wait_cycles;

  modport master (
    input  cmd_valid, cmd_layer_type, cmd_pooling, cmd_relu, cmd_ch_num, cmd_pix_num,
           cmd_row_num, cmd_shift, cmd_pe_mask, cmd_tile_num, cmd_act_base, cmd_act_stride,
           cmd_act_len, cmd_mask_base, cmd_mask_stride, cmd_mask_len,
           dg_done, wcmd1_ready, wcmd2_ready,
    output cmd_ready, dg_start, dg_layer_type, dg_pooling, dg_relu, dg_ch_num, dg_pix_num,
           dg_row_num, dg_shift, dg_pe_sel, wcmd1_valid, wcmd1_addr, wcmd1_len,
           wcmd2_valid, wcmd2_addr, wcmd2_len, layer_done, busy,
           perf_busy_cycles, perf_wait_cycles
  );

  modport slave (
    output cmd_valid, cmd_layer_type, cmd_pooling, cmd_relu, cmd_ch_num, cmd_pix_num,
           cmd_row_num, cmd_shift, cmd_pe_mask, cmd_tile_num, cmd_act_base, cmd_act_stride,
           cmd_act_len, cmd_mask_base, cmd_mask_stride, cmd_mask_len,
           dg_done, wcmd1_ready, wcmd2_ready,
    input  cmd_ready, dg_start, dg_layer_type, dg_pooling, dg_relu, dg_ch_num, dg_pix_num,
           dg_row_num, dg_shift, dg_pe_sel, wcmd1_valid, wcmd1_addr, wcmd1_len,
           wcmd2_valid, wcmd2_addr, wcmd2_len, layer_done, busy,
           perf_busy_cycles, perf_wait_cycles
  );
endinterface

// File: rtl/pe2ddr_sched.sv
// rtl/pe2ddr_sched.sv - per-layer tile/quadrant scheduler for PE-to-DDR write-back; SCHED_PERF_EN adds perf counters
module pe2ddr_sched #(
  parameter int ADDR_W = 32,
  parameter int LEN_W  = 16,
  parameter int TILE_W = 8
) (
  input logic             clk,
  input logic             rst,
  pe2ddr_sched_if.master  bus
);
  typedef enum logic [2:0] {IDLE, ISSUE, START, GAP, WAIT, NEXT, FIN} state_t;

  state_t            state;
  logic [3:0]        pe_mask;
  logic [TILE_W-1:0] tile_num;
  logic [TILE_W-1:0] tile_cnt;
  logic [ADDR_W-1:0] act_stride;
  logic [ADDR_W-1:0] mask_stride;
  logic [1:0]        cmd_low_sel;
  logic [1:0]        low_sel;
  logic [1:0]        next_sel;
  logic              has_next;
  logic              wcmd1_clear;
  logic              wcmd2_clear;

  // Quadrant lookup: lowest set bit of the incoming and latched masks, and next set bit above the current job
  always_comb begin
    cmd_low_sel = 2'd0;
    low_sel     = 2'd0;
    next_sel    = 2'd0;
    has_next    = 1'b0;
    for (int k = 3; k >= 0; k--) begin
      if (bus.cmd_pe_mask[k]) cmd_low_sel = 2'(k);
      if (pe_mask[k]) low_sel = 2'(k);
      if (pe_mask[k] && (k > int'(bus.dg_pe_sel))) begin
        has_next = 1'b1;
        next_sel = 2'(k);
      end
    end
  end

  // A channel is finished once its valid is low or is being accepted this cycle
  assign wcmd1_clear = !bus.wcmd1_valid || bus.wcmd1_ready;
  assign wcmd2_clear = !bus.wcmd2_valid || bus.wcmd2_ready;

  // Layer walk FSM; every output is a register so the generator and DDR engines see glitch-free controls
  always_ff @(posedge clk) begin
    if (rst) begin
      state             <= IDLE;
      bus.cmd_ready     <= 1'b1;
      bus.busy          <= 1'b0;
      bus.dg_start      <= 1'b0;
      bus.wcmd1_valid   <= 1'b0;
      bus.wcmd2_valid   <= 1'b0;
      bus.layer_done    <= 1'b0;
      bus.dg_layer_type <= '0;
      bus.dg_pooling    <= 1'b0;
      bus.dg_relu       <= 1'b0;
      bus.dg_ch_num     <= '0;
      bus.dg_pix_num    <= '0;
      bus.dg_row_num    <= '0;
      bus.dg_shift      <= '0;
      bus.dg_pe_sel     <= '0;
      bus.wcmd1_addr    <= '0;
      bus.wcmd1_len     <= '0;
      bus.wcmd2_addr    <= '0;
      bus.wcmd2_len     <= '0;
      pe_mask           <= '0;
      tile_num          <= '0;
      tile_cnt          <= '0;
      act_stride        <= '0;
      mask_stride       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.cmd_valid) begin
            bus.dg_layer_type <= bus.cmd_layer_type;
            bus.dg_pooling    <= bus.cmd_pooling;
            bus.dg_relu       <= bus.cmd_relu;
            bus.dg_ch_num     <= bus.cmd_ch_num;
            bus.dg_pix_num    <= bus.cmd_pix_num;
            bus.dg_row_num    <= bus.cmd_row_num;
            bus.dg_shift      <= bus.cmd_shift;
            bus.dg_pe_sel     <= cmd_low_sel;
            bus.wcmd1_addr    <= bus.cmd_act_base;
            bus.wcmd1_len     <= bus.cmd_act_len;
            bus.wcmd2_addr    <= bus.cmd_mask_base;
            bus.wcmd2_len     <= bus.cmd_mask_len;
            pe_mask           <= bus.cmd_pe_mask;
            tile_num          <= bus.cmd_tile_num;
            tile_cnt          <= '0;
            act_stride        <= bus.cmd_act_stride;
            mask_stride       <= bus.cmd_mask_stride;
            bus.cmd_ready     <= 1'b0;
            bus.busy          <= 1'b1;
            if (bus.cmd_pe_mask == 4'd0) begin
              state          <= FIN;
              bus.layer_done <= 1'b1;
            end else begin
              state           <= ISSUE;
              bus.wcmd1_valid <= 1'b1;
              bus.wcmd2_valid <= !bus.cmd_layer_type[1];
            end
          end
        end
        ISSUE: begin
          if (bus.wcmd1_ready) bus.wcmd1_valid <= 1'b0;
          if (bus.wcmd2_ready) bus.wcmd2_valid <= 1'b0;
          if (wcmd1_clear && wcmd2_clear) begin
            state        <= START;
            bus.dg_start <= 1'b1;
          end
        end
        START: begin
          bus.dg_start <= 1'b0;
          state        <= GAP;
        end
        GAP: state <= WAIT;
        WAIT: begin
          if (bus.dg_done) state <= NEXT;
        end
        NEXT: begin
          bus.wcmd1_addr <= bus.wcmd1_addr + act_stride;
          bus.wcmd2_addr <= bus.wcmd2_addr + mask_stride;
          if (has_next) begin
            bus.dg_pe_sel <= next_sel;
          end else begin
            bus.dg_pe_sel <= low_sel;
            tile_cnt      <= tile_cnt + 1'b1;
          end
          if (!has_next && (tile_cnt == tile_num)) begin
            state          <= FIN;
            bus.layer_done <= 1'b1;
          end else begin
            state           <= ISSUE;
            bus.wcmd1_valid <= 1'b1;
            bus.wcmd2_valid <= !bus.dg_layer_type[1];
          end
        end
        FIN: begin
          bus.layer_done <= 1'b0;
          bus.busy       <= 1'b0;
          bus.cmd_ready  <= 1'b1;
          state          <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef SCHED_PERF_EN
  logic [31:0] perf_busy;
  logic [31:0] perf_wait;

  // Saturating busy and generator-wait residency counters, restarted by each accepted command
  always_ff @(posedge clk) begin
    if (rst) begin
      perf_busy <= '0;
      perf_wait <= '0;
    end else if ((state == IDLE) && bus.cmd_valid) begin
      perf_busy <= '0;
      perf_wait <= '0;
    end else begin
      if (bus.busy && (perf_busy != 32'hFFFF_FFFF)) perf_busy <= perf_busy + 32'd1;
      if ((state == WAIT) && (perf_wait != 32'hFFFF_FFFF)) perf_wait <= perf_wait + 32'd1;
    end
  end

  assign bus.perf_busy_cycles = perf_busy;
  assign bus.perf_wait_cycles = perf_wait;
`else
  assign bus.perf_busy_cycles = 32'd0;
  assign bus.perf_wait_cycles = 32'd0;
`endif
endmodule
